tl_cntr_w_left_fsm: RTL and testbench
=====================================

// Module: tl_cntr_w_left_fsm
// PURPOSE
//  Traffic-light controller with protected left-turn phases for a two-road junction (A, B).
//  Holds an 8-state Moore sequence in a 3-bit state register.
//  Decodes that state into per-road light codes.
//  A dwell counter times the yellow phases and caps green/left phases, so a busy road cannot starve the other.
// PARAMETERS
//  CNT_W       4  width of dwell counter; counter saturates at 2**CNT_W-1
//  YELLOW_CYC  2  cycles spent in each yellow state; legal 1..2**CNT_W-1
//  MAX_HOLD    8  max cycles in a green/left state; 0 = no cap; legal 0..2**CNT_W-1
// PORTS
//  clk      in   1  rising-edge clock
//  reset_n  in   1  synchronous, active-low reset
//  Ta       in   1  traffic present on road A straight
//  Tal      in   1  traffic waiting to turn left from A
//  Tb       in   1  traffic present on road B straight
//  Tbl      in   1  traffic waiting to turn left from B
//  La       out  2  road A light: 00 green, 01 yellow, 10 left, 11 red
//  Lb       out  2  road B light: same encoding as La
//  state    out  3  current state (debug/observe)
// BEHAVIOUR
//  Clocking and reset
//   - One clock, synchronous active-low reset.
//   - At any rising edge with reset_n=0: state<=S0, cnt<=0. This holds mid-phase too, including mid-yellow.
//   - Reset outputs: state=000, La=00, Lb=11.
//  Outputs
//   - Moore machine. La, Lb and state are a pure decode of the registered state.
//   - Outputs change in the same cycle as the state, one clock after the deciding inputs are sampled.
//  States (encoding = index)
//   S0: A green, B red
//   S1: A yellow, B red
//   S2: A left, B red
//   S3: A yellow, B red
//   S4: A red, B green
//   S5: A red, B yellow
//   S6: A red, B left
//   S7: A red, B yellow
//  Dwell counter cnt [CNT_W-1:0]
//   - Cleared to 0 on every edge where the state changes.
//   - Otherwise increments, saturating at 2**CNT_W-1.
//  Hold states: S0 (sensor Ta), S2 (Tal), S4 (Tb), S6 (Tbl)
//   - Leave when sensor==0, OR when MAX_HOLD!=0 and cnt==MAX_HOLD-1.
//   - Otherwise stay.
//   - Sensor low on entry: state lasts exactly 1 cycle.
//   - Sensor held high: state lasts exactly MAX_HOLD cycles.
//  Yellow states: S1, S3, S5, S7
//   - Leave when cnt==YELLOW_CYC-1, i.e. exactly YELLOW_CYC cycles. Sensors are ignored.
//  Transition order: S0->S1->S2->S3->S4->S5->S6->S7->S0. No other transitions exist.
//  Simultaneous events
//   - Reset has priority over every transition.
//   - In a hold state, the sensor dropping and the cap hitting on the same edge give a single transition.
//  Safety invariant: La!=11 implies Lb==11, and Lb!=11 implies La==11, in every cycle.
// TESTING
//  1. reset_n=0 for 2 edges, all sensors 1 -> state=0, La=00, Lb=11; remains S0 while reset_n=0.
//  2. Ta=Tal=Tb=Tbl=0 after reset, defaults -> states 0,1,1,2,3,3,4,5,5,6,7,7,0 on successive cycles.
//  3. Ta=1 constantly, MAX_HOLD=8 -> S0 held exactly 8 cycles, then S1 for 2 cycles.
//  4. Rerun scenario 3 with MAX_HOLD=0 -> S0 held indefinitely (check 40 cycles).
//     Drop Ta -> S1 on the next edge.
//  5. Tbl=1 in S6, drop Tbl after 3 cycles -> S6 lasts 4 cycles, then S7 for 2 cycles, then S0.
//  6. reset_n=0 for one edge while in S5 with cnt=1 -> next cycle state=0, La=00, Lb=11, cnt=0.
//  All scenarios: assert the safety invariant every cycle. Compare against a behavioural reference model.

Source files
------------

// File: rtl/tl_cntr_w_left_fsm.sv
// Two-road traffic-light controller with protected left-turn phases.
// The 8-state Moore sequence is timed by a saturating dwell counter that caps green and left phases.
module tl_cntr_w_left_fsm #(
    parameter int unsigned CNT_W      = 4,
    parameter int unsigned YELLOW_CYC = 2,
    parameter int unsigned MAX_HOLD   = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       Ta,
    input  logic       Tal,
    input  logic       Tb,
    input  logic       Tbl,
    output logic [1:0] La,
    output logic [1:0] Lb,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S0_A_GREEN  = 3'd0,
        S1_A_YELLOW = 3'd1,
        S2_A_LEFT   = 3'd2,
        S3_A_YELLOW = 3'd3,
        S4_B_GREEN  = 3'd4,
        S5_B_YELLOW = 3'd5,
        S6_B_LEFT   = 3'd6,
        S7_B_YELLOW = 3'd7
    } state_t;

    localparam logic [1:0] L_GREEN  = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_LEFT   = 2'b10;
    localparam logic [1:0] L_RED    = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(MAX_HOLD - 1);
    localparam bit               HOLD_CAPPED = (MAX_HOLD != 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hold_sensor;
    logic             leave;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S0_A_GREEN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Even states are the sensor-driven hold phases; odd states are yellows.
    always_comb begin
        hold_sensor = 1'b0;
        case (state_q)
            S0_A_GREEN: hold_sensor = Ta;
            S2_A_LEFT:  hold_sensor = Tal;
            S4_B_GREEN: hold_sensor = Tb;
            S6_B_LEFT:  hold_sensor = Tbl;
            default:    hold_sensor = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        leave   = 1'b0;
        if (state_q[0]) begin
            leave = (cnt_q == YELLOW_LAST);
        end else begin
            leave = !hold_sensor || (HOLD_CAPPED && (cnt_q == HOLD_LAST));
        end
        if (leave) begin
            state_d = state_t'(state_q + 3'd1);
            cnt_d   = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        La = L_RED;
        Lb = L_RED;
        case (state_q)
            S0_A_GREEN:  La = L_GREEN;
            S1_A_YELLOW: La = L_YELLOW;
            S2_A_LEFT:   La = L_LEFT;
            S3_A_YELLOW: La = L_YELLOW;
            S4_B_GREEN:  Lb = L_GREEN;
            S5_B_YELLOW: Lb = L_YELLOW;
            S6_B_LEFT:   Lb = L_LEFT;
            S7_B_YELLOW: Lb = L_YELLOW;
            default: begin
                La = L_RED;
                Lb = L_RED;
            end
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_tl_cntr_w_left_fsm.sv
// Bench for tl_cntr_w_left_fsm: a capped (MAX_HOLD=8) and an uncapped (MAX_HOLD=0) instance
// share stimulus and are each compared against a time-in-phase reference model every cycle.
module tb_tl_cntr_w_left_fsm;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       Ta, Tal, Tb, Tbl;
    logic [1:0] la8, lb8, la0, lb0;
    logic [2:0] st8, st0;

    always #5 clk = ~clk;

    tl_cntr_w_left_fsm #(.CNT_W(4), .YELLOW_CYC(2), .MAX_HOLD(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .Ta(Ta), .Tal(Tal), .Tb(Tb), .Tbl(Tbl),
        .La(la8), .Lb(lb8), .state(st8)
    );

    tl_cntr_w_left_fsm #(.CNT_W(4), .YELLOW_CYC(2), .MAX_HOLD(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .Ta(Ta), .Tal(Tal), .Tb(Tb), .Tbl(Tbl),
        .La(la0), .Lb(lb0), .state(st0)
    );

    int tests  = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference: phase index plus the number of whole cycles already spent in it.
    int m_st [2];
    int m_dw [2];
    int m_mh [2] = '{8, 0};
    int yellow_cyc = 2;
    int la_tab [8] = '{0, 1, 2, 1, 3, 3, 3, 3};
    int lb_tab [8] = '{3, 3, 3, 3, 0, 1, 2, 1};
    int seq2 [13]  = '{0, 1, 1, 2, 3, 3, 4, 5, 5, 6, 7, 7, 0};

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        bit sensor;
        bit leave;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                m_st[k] = 0;
                m_dw[k] = 0;
            end else begin
                if (m_st[k] % 2 == 1) begin
                    leave = (m_dw[k] + 1 == yellow_cyc);
                end else begin
                    case (m_st[k] / 2)
                        0: sensor = Ta;
                        1: sensor = Tal;
                        2: sensor = Tb;
                        default: sensor = Tbl;
                    endcase
                    leave = !sensor || (m_mh[k] != 0 && m_dw[k] + 1 == m_mh[k]);
                end
                if (leave) begin
                    m_st[k] = (m_st[k] + 1) % 8;
                    m_dw[k] = 0;
                end else begin
                    m_dw[k]++;
                end
            end
        end
        @(negedge clk);
        cyc++;
        check("st8", int'(st8), m_st[0]);
        check("la8", int'(la8), la_tab[m_st[0]]);
        check("lb8", int'(lb8), lb_tab[m_st[0]]);
        check("st0", int'(st0), m_st[1]);
        check("la0", int'(la0), la_tab[m_st[1]]);
        check("lb0", int'(lb0), lb_tab[m_st[1]]);
        check("safe8", int'(la8 == 2'b11 || lb8 == 2'b11), 1);
        check("safe0", int'(la0 == 2'b11 || lb0 == 2'b11), 1);
        $display("[TB] cyc=%0d rst_n=%0b T=%0b%0b%0b%0b st8=%0d La8=%0d Lb8=%0d st0=%0d La0=%0d Lb0=%0d",
                 cyc, reset_n, Ta, Tal, Tb, Tbl, st8, la8, lb8, st0, la0, lb0);
    endtask

    task automatic set_sensors(input bit a, input bit al, input bit b, input bit bl);
        Ta = a; Tal = al; Tb = b; Tbl = bl;
    endtask

    // Two reset edges with all sensors high, then release with the given sensors.
    task automatic do_reset(input bit a, input bit al, input bit b, input bit bl);
        reset_n = 1'b0;
        set_sensors(1, 1, 1, 1);
        step();
        check("rst_st", int'(st8), 0);
        step();
        check("rst_st_hold", int'(st8), 0);
        check("rst_la", int'(la8), 0);
        check("rst_lb", int'(lb8), 3);
        reset_n = 1'b1;
        set_sensors(a, al, b, bl);
    endtask

    task automatic wait8(input int tgt, input int budget);
        int n = 0;
        while (int'(st8) != tgt && n < budget) begin
            step();
            n++;
        end
        check("wait_state", int'(st8), tgt);
    endtask

    initial begin
        reset_n = 1'b0;
        set_sensors(1, 1, 1, 1);
        m_st = '{0, 0};
        m_dw = '{0, 0};
        @(negedge clk);

        // All sensors idle: every hold phase lasts one cycle, every yellow two.
        do_reset(0, 0, 0, 0);
        for (int i = 0; i < 13; i++) begin
            if (i > 0) step();
            check("seq_idle8", int'(st8), seq2[i]);
            check("seq_idle0", int'(st0), seq2[i]);
        end

        // Ta held high: capped instance holds S0 exactly 8 cycles, uncapped never leaves.
        do_reset(1, 0, 0, 0);
        for (int i = 2; i <= 8; i++) begin
            step();
            check("cap_hold", int'(st8), 0);
        end
        step();
        check("cap_y1", int'(st8), 1);
        step();
        check("cap_y2", int'(st8), 1);
        step();
        check("cap_left", int'(st8), 2);
        for (int i = 12; i <= 40; i++) begin
            step();
            check("nocap_hold", int'(st0), 0);
        end
        Ta = 1'b0;
        step();
        check("nocap_drop", int'(st0), 1);

        // B left with Tbl dropped after three cycles in S6.
        do_reset(0, 0, 0, 1);
        wait8(6, 40);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bl_hold", int'(st8), 6);
        end
        Tbl = 1'b0;
        step();
        check("bl_y1", int'(st8), 7);
        step();
        check("bl_y2", int'(st8), 7);
        step();
        check("bl_wrap", int'(st8), 0);

        // Reset mid-yellow (S5, second cycle) must restart S0 with a cleared counter.
        do_reset(0, 0, 0, 0);
        wait8(5, 40);
        step();
        check("y_mid", int'(st8), 5);
        reset_n = 1'b0;
        step();
        check("midrst_st", int'(st8), 0);
        check("midrst_la", int'(la8), 0);
        check("midrst_lb", int'(lb8), 3);
        reset_n = 1'b1;
        Ta = 1'b1;
        for (int i = 2; i <= 8; i++) begin
            step();
            check("midrst_hold", int'(st8), 0);
        end
        step();
        check("midrst_leave", int'(st8), 1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            reset_n = ($urandom_range(0, 39) != 0);
            set_sensors($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                        $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
